// File: rtl/acq_pkg.sv
// Shared types and default constants for the acquisition sequencer.
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        TRIG  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } acq_state_e;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_FRAME_W  = 8;
    localparam int DEF_ARM_DLY  = 4;
    localparam int DEF_TRIG_LEN = 8;

    // FRC_IN cycles per generator step; TRIG must outlast one step to be seen.
    localparam int GEN_STEP = 6;

endpackage

// File: rtl/acq_sequencer_if.sv
// Host/generator/memory signal bundle of the acquisition sequencer.
// Signal prefixes are from the sequencer's point of view.
interface acq_sequencer_if
    import acq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int FRAME_W = DEF_FRAME_W
);
    logic               i_start;
    logic               i_abort;
    logic [FRAME_W-1:0] i_nFrames;
    logic               i_wrStb;
    logic               i_f5;
    logic               o_counterFGo;
    logic               o_trig;
    logic               o_memWe;
    logic [ADDR_W-1:0]  o_memAddr;
    logic [FRAME_W-1:0] o_frameCnt;
    logic               o_busy;
    logic               o_done;
    logic               o_ovf;

    modport master (
        output i_start, i_abort, i_nFrames, i_wrStb, i_f5,
        input  o_counterFGo, o_trig, o_memWe, o_memAddr, o_frameCnt, o_busy, o_done, o_ovf
    );

    modport slave (
        input  i_start, i_abort, i_nFrames, i_wrStb, i_f5,
        output o_counterFGo, o_trig, o_memWe, o_memAddr, o_frameCnt, o_busy, o_done, o_ovf
    );

endinterface

// File: rtl/edge_det.sv
// Registered edge detector: rise/fall appear one cycle after the input is sampled.
module edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
            r_fall <= ~i_sig & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the sync generator, triggers it, counts F-cycles
// and turns generator write strobes into addressed single-cycle memory writes.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int FRAME_W  = DEF_FRAME_W,
    parameter int ARM_DLY  = DEF_ARM_DLY,
    parameter int TRIG_LEN = DEF_TRIG_LEN
) (
    input  logic i_frcIn,
    input  logic i_resHard,
    acq_sequencer_if.slave bus
);

    // Out-of-range settings are clamped so the generator always sees a usable TRIG.
    localparam int ARM_CYC  = (ARM_DLY < 1) ? 1 : ((ARM_DLY > 15) ? 15 : ARM_DLY);
    localparam int TRIG_CYC = (TRIG_LEN > GEN_STEP) ? TRIG_LEN : GEN_STEP + 1;
    localparam int DLY_MAX  = (TRIG_CYC > ARM_CYC) ? TRIG_CYC : ARM_CYC;
    localparam int DLY_W    = $clog2(DLY_MAX) + 1;
    localparam logic [DLY_W-1:0] ARM_LAST  = DLY_W'(ARM_CYC - 1);
    localparam logic [DLY_W-1:0] TRIG_LAST = DLY_W'(TRIG_CYC - 1);

    acq_state_e         r_state;
    acq_state_e         w_nextState;
    logic [DLY_W-1:0]   r_dly;
    logic [FRAME_W-1:0] r_nFrames;
    logic [FRAME_W-1:0] r_frameCnt;
    logic [ADDR_W-1:0]  r_memAddr;
    logic               r_ovf;
    logic               r_done;

    logic w_startRise;
    logic w_wrRise;
    logic w_f5Fall;
    logic w_unusedStartFall;
    logic w_unusedWrFall;
    logic w_unusedF5Rise;

    logic w_accept;
    logic w_emptyStart;
    logic w_frameTick;
    logic w_lastFrame;
    logic w_memWe;
    logic w_drainDone;

    edge_det u_startEdge (.i_clk(i_frcIn), .i_rst(i_resHard), .i_sig(bus.i_start),
                          .o_rise(w_startRise), .o_fall(w_unusedStartFall));
    edge_det u_wrEdge    (.i_clk(i_frcIn), .i_rst(i_resHard), .i_sig(bus.i_wrStb),
                          .o_rise(w_wrRise), .o_fall(w_unusedWrFall));
    edge_det u_f5Edge    (.i_clk(i_frcIn), .i_rst(i_resHard), .i_sig(bus.i_f5),
                          .o_rise(w_unusedF5Rise), .o_fall(w_f5Fall));

    assign w_accept     = (r_state == IDLE) && w_startRise && (bus.i_nFrames != '0);
    assign w_emptyStart = (r_state == IDLE) && w_startRise && (bus.i_nFrames == '0);
    assign w_frameTick  = (r_state == RUN) && w_f5Fall && !bus.i_abort;
    assign w_lastFrame  = w_frameTick && ((r_frameCnt + FRAME_W'(1)) == r_nFrames);
    assign w_memWe      = ((r_state == TRIG) || (r_state == RUN) || (r_state == DRAIN)) && w_wrRise;
    // DRAIN exits on the raw strobe level so a late rise still reaches MEM_WE first.
    assign w_drainDone  = (r_state == DRAIN) && !bus.i_abort && !bus.i_wrStb;

    always_ff @(posedge i_frcIn) begin
        if (i_resHard) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if ((r_state != IDLE) && bus.i_abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept)            w_nextState = ARM;
                ARM:     if (r_dly == ARM_LAST)   w_nextState = TRIG;
                TRIG:    if (r_dly == TRIG_LAST)  w_nextState = RUN;
                RUN:     if (w_lastFrame)         w_nextState = DRAIN;
                DRAIN:   if (!bus.i_wrStb)        w_nextState = IDLE;
                default:                          w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_busy       = (r_state != IDLE);
        bus.o_counterFGo = (r_state != IDLE);
        bus.o_trig       = (r_state == TRIG);
        bus.o_memWe      = w_memWe;
    end

    always_ff @(posedge i_frcIn) begin
        if (i_resHard) begin
            r_dly      <= '0;
            r_nFrames  <= '0;
            r_frameCnt <= '0;
            r_memAddr  <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_emptyStart || w_drainDone;

            if (((r_state == ARM) || (r_state == TRIG)) && (w_nextState == r_state)) begin
                r_dly <= r_dly + DLY_W'(1);
            end else begin
                r_dly <= '0;
            end

            if (w_accept) begin
                r_nFrames  <= bus.i_nFrames;
                r_frameCnt <= '0;
                r_memAddr  <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_frameTick) begin
                    r_frameCnt <= r_frameCnt + FRAME_W'(1);
                end
                // Address advances after the write so MEM_WE uses the pre-increment value.
                if (w_memWe) begin
                    r_memAddr <= r_memAddr + ADDR_W'(1);
                    if (&r_memAddr) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_memAddr  = r_memAddr;
    assign bus.o_frameCnt = r_frameCnt;
    assign bus.o_ovf      = r_ovf;
    assign bus.o_done     = r_done;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with a 3-bit address space so wrap is reachable.
module tb_acq_sequencer;
    import acq_pkg::*;

    localparam int AW = 3;
    localparam int FW = 8;
    localparam int NVEC = 18;

    typedef struct packed {
        logic          busy;
        logic          go;
        logic          trig;
        logic          memWe;
        logic          done;
        logic          ovf;
        logic [AW-1:0] addr;
        logic [FW-1:0] cnt;
    } outs_t;

    typedef struct {
        logic          start;
        logic          abort;
        logic [FW-1:0] nFrames;
        logic          wrStb;
        logic          f5;
        int            reps;
        outs_t         exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nApplied = 0;
    int   nMiscompare = 0;
    int   weCount = 0;
    int   weBefore;
    vec_t vecs [NVEC];

    always #5 clock = ~clock;

    acq_sequencer_if #(.ADDR_W(AW), .FRAME_W(FW)) bus ();

    acq_sequencer #(.ADDR_W(AW), .FRAME_W(FW), .ARM_DLY(4), .TRIG_LEN(8)) dut (
        .i_frcIn  (clock),
        .i_resHard(reset),
        .bus      (bus)
    );

    always @(negedge clock) begin
        if (bus.o_memWe === 1'b1) weCount++;
    end

    function automatic outs_t mkOut(input int b, input int g, input int t, input int w,
                                    input int d, input int o, input int a, input int c);
        outs_t r;
        r.busy  = 1'(b);
        r.go    = 1'(g);
        r.trig  = 1'(t);
        r.memWe = 1'(w);
        r.done  = 1'(d);
        r.ovf   = 1'(o);
        r.addr  = AW'(a);
        r.cnt   = FW'(c);
        return r;
    endfunction

    function automatic vec_t mkVec(input int s, input int n, input int w, input int f,
                                   input int reps, input outs_t e);
        vec_t v;
        v.start   = 1'(s);
        v.abort   = 1'b0;
        v.nFrames = FW'(n);
        v.wrStb   = 1'(w);
        v.f5      = 1'(f);
        v.reps    = reps;
        v.exp     = e;
        return v;
    endfunction

    function automatic outs_t sampleOutputs();
        outs_t r;
        r.busy  = bus.o_busy;
        r.go    = bus.o_counterFGo;
        r.trig  = bus.o_trig;
        r.memWe = bus.o_memWe;
        r.done  = bus.o_done;
        r.ovf   = bus.o_ovf;
        r.addr  = bus.o_memAddr;
        r.cnt   = bus.o_frameCnt;
        return r;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic tickN(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.i_start   = v.start;
        bus.i_abort   = v.abort;
        bus.i_nFrames = v.nFrames;
        bus.i_wrStb   = v.wrStb;
        bus.i_f5      = v.f5;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sampleOutputs();
        nApplied++;
        if (act !== exp) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got busy=%b go=%b trig=%b we=%b done=%b ovf=%b addr=%0d cnt=%0d, want busy=%b go=%b trig=%b we=%b done=%b ovf=%b addr=%0d cnt=%0d",
                     name, act.busy, act.go, act.trig, act.memWe, act.done, act.ovf, act.addr, act.cnt,
                     exp.busy, exp.go, exp.trig, exp.memWe, exp.done, exp.ovf, exp.addr, exp.cnt);
        end
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        // Basic run with N_FRAMES=2: 4 ARM cycles, 8 TRIG cycles, writes, drain, then an empty START.
        vecs[0]  = mkVec(1, 2, 0, 0, 1, mkOut(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mkVec(1, 2, 0, 0, 4, mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        vecs[2]  = mkVec(1, 2, 0, 0, 8, mkOut(1, 1, 1, 0, 0, 0, 0, 0));
        vecs[3]  = mkVec(0, 2, 0, 0, 1, mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        vecs[4]  = mkVec(0, 2, 0, 1, 2, mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        vecs[5]  = mkVec(0, 2, 0, 0, 1, mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        vecs[6]  = mkVec(0, 2, 0, 0, 1, mkOut(1, 1, 0, 0, 0, 0, 0, 1));
        vecs[7]  = mkVec(0, 2, 1, 0, 1, mkOut(1, 1, 0, 1, 0, 0, 0, 1));
        vecs[8]  = mkVec(0, 2, 1, 0, 6, mkOut(1, 1, 0, 0, 0, 0, 1, 1));
        vecs[9]  = mkVec(0, 2, 0, 0, 2, mkOut(1, 1, 0, 0, 0, 0, 1, 1));
        vecs[10] = mkVec(0, 2, 1, 1, 1, mkOut(1, 1, 0, 1, 0, 0, 1, 1));
        vecs[11] = mkVec(0, 2, 1, 0, 1, mkOut(1, 1, 0, 0, 0, 0, 2, 1));
        vecs[12] = mkVec(0, 2, 1, 0, 3, mkOut(1, 1, 0, 0, 0, 0, 2, 2));
        vecs[13] = mkVec(0, 2, 0, 0, 1, mkOut(0, 0, 0, 0, 1, 0, 2, 2));
        vecs[14] = mkVec(0, 2, 0, 0, 2, mkOut(0, 0, 0, 0, 0, 0, 2, 2));
        vecs[15] = mkVec(1, 0, 0, 0, 1, mkOut(0, 0, 0, 0, 0, 0, 2, 2));
        vecs[16] = mkVec(1, 0, 0, 0, 1, mkOut(0, 0, 0, 0, 1, 0, 2, 2));
        vecs[17] = mkVec(0, 0, 0, 0, 2, mkOut(0, 0, 0, 0, 0, 0, 2, 2));

        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_nFrames = '0;
        bus.i_wrStb = 1'b0;
        bus.i_f5 = 1'b0;
        tickN(3);
        checkOutput("reset", mkOut(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            for (int r = 0; r < vecs[i].reps; r++) begin
                tick();
                checkOutput($sformatf("vec%0d.%0d", i, r), vecs[i].exp);
            end
        end

        // Run with N_FRAMES=3: one frame, nine writes through the wrap, then abort.
        bus.i_nFrames = 8'd3;
        bus.i_start = 1'b1;
        tickN(2);
        checkOutput("accept3", mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        bus.i_start = 1'b0;
        tickN(12);
        checkOutput("runEntry3", mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        bus.i_f5 = 1'b1;
        tick();
        bus.i_f5 = 1'b0;
        tickN(2);
        checkOutput("frame1", mkOut(1, 1, 0, 0, 0, 0, 0, 1));

        weBefore = weCount;
        for (int i = 0; i < 9; i++) begin
            bus.i_wrStb = 1'b1;
            tick();
            checkField($sformatf("wePulse%0d", i), int'(bus.o_memWe), 1);
            checkField($sformatf("weAddr%0d", i), int'(bus.o_memAddr), i % 8);
            tick();
            checkField($sformatf("weSingle%0d", i), int'(bus.o_memWe), 0);
            tickN(5);
            bus.i_wrStb = 1'b0;
            tickN(2);
            checkField($sformatf("ovf%0d", i), int'(bus.o_ovf), (i >= 7) ? 1 : 0);
        end
        checkField("weCount", weCount - weBefore, 9);
        checkField("addrAfterWrap", int'(bus.o_memAddr), 1);

        bus.i_abort = 1'b1;
        tick();
        checkOutput("abort", mkOut(0, 0, 0, 0, 0, 1, 1, 1));
        bus.i_abort = 1'b0;
        tick();
        checkOutput("abortNoDone", mkOut(0, 0, 0, 0, 0, 1, 1, 1));

        // N_FRAMES=1 run: clears OVF, ignores a START rise in RUN, drains and completes.
        bus.i_nFrames = 8'd1;
        bus.i_start = 1'b1;
        tickN(2);
        checkOutput("restartClearsOvf", mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        bus.i_start = 1'b0;
        tickN(12);
        checkOutput("runEntry1", mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        bus.i_start = 1'b1;
        tickN(10);
        checkOutput("startIgnored", mkOut(1, 1, 0, 0, 0, 0, 0, 0));
        bus.i_start = 1'b0;
        bus.i_f5 = 1'b1;
        tick();
        bus.i_f5 = 1'b0;
        tickN(2);
        checkOutput("drainEntry", mkOut(1, 1, 0, 0, 0, 0, 0, 1));
        tick();
        checkOutput("doneN1", mkOut(0, 0, 0, 0, 1, 0, 0, 1));
        tick();
        checkOutput("doneOnce", mkOut(0, 0, 0, 0, 0, 0, 0, 1));

        // Hard reset in the middle of TRIG.
        bus.i_nFrames = 8'd5;
        bus.i_start = 1'b1;
        tickN(7);
        checkOutput("inTrig", mkOut(1, 1, 1, 0, 0, 0, 0, 0));
        reset = 1'b1;
        tick();
        checkOutput("resetMidTrig", mkOut(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        bus.i_start = 1'b0;
        tickN(2);
        checkOutput("postReset", mkOut(0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Acquisition sequencer for the 4-phase / 6-phase sync generator.
- On a host START it enables the generator (COUNTER_F_GO), issues a TRIG pulse to restart the F-phase and board counters, then counts complete F-cycles (falling edges of F5) up to N_FRAMES.
- During the run it turns each generator WRITE_TOO_MEM strobe into a single-cycle memory write with an auto-incrementing address.
- It sits between the host/control register file and the sync generator, and also drives the sample-memory write port.

Parameters:
ADDR_W    12   width of MEM_ADDR; address space 2^ADDR_W words
FRAME_W   8    width of N_FRAMES / FRAME_CNT
ARM_DLY   4    FRC_IN cycles that COUNTER_F_GO is held high before TRIG asserts (range 1..15)
TRIG_LEN  8    FRC_IN cycles TRIG is held high; must exceed one generator step (6 FRC_IN cycles)

Ports:
FRC_IN      in   1        master clock; all logic on rising edge
RES_HARD    in   1        synchronous reset, active-high
START       in   1        level; rising edge starts a run
ABORT       in   1        level; while high, forces return to IDLE
N_FRAMES    in   FRAME_W  F-cycles per run; sampled on the START edge
WR_STB      in   1        WRITE_TOO_MEM from the sync generator
F5          in   1        last F-phase from the sync generator
COUNTER_F_GO out 1        generator enable
TRIG        out  1        generator restart
MEM_WE      out  1        one-cycle memory write strobe
MEM_ADDR    out  ADDR_W   current write address
FRAME_CNT   out  FRAME_W  completed F-cycles in the current run
BUSY        out  1        high in every state except IDLE
DONE        out  1        one-cycle pulse at normal completion
OVF         out  1        sticky flag: address wrapped during the run

Behaviour:
- Reset: all outputs 0, state IDLE, edge registers 0. Reset wins over every other input, including mid-run.
- Edge detection:
  - START, WR_STB and F5 are each registered once (prev copy).
  - rise = x & ~x_prev; fall = ~x & x_prev.
  - All decisions use these registered edges, so each edge has one cycle of latency.
- State machine:
  - IDLE → ARM on START rise when N_FRAMES != 0. This transition loads N_FRAMES, clears FRAME_CNT, MEM_ADDR and OVF, and sets COUNTER_F_GO=1.
  - START rise with N_FRAMES == 0: stay IDLE, pulse DONE next cycle, leave counters unchanged.
  - ARM: hold for ARM_DLY cycles, then → TRIG.
  - TRIG: drive TRIG=1 for TRIG_LEN cycles, then → RUN with TRIG=0.
  - RUN: each F5 fall increments FRAME_CNT. When the increment makes FRAME_CNT equal the latched N_FRAMES, → DRAIN.
  - DRAIN: stay while WR_STB == 1. On the first cycle with WR_STB == 0: COUNTER_F_GO=0, DONE=1 for one cycle, → IDLE.
  - ABORT==1 in any non-IDLE state: → IDLE next cycle, COUNTER_F_GO=0, TRIG=0, no DONE pulse. MEM_ADDR, FRAME_CNT and OVF keep their values.
  - START rise while BUSY: ignored.
- Memory write:
  - In TRIG, RUN and DRAIN, a WR_STB rise gives MEM_WE=1 for exactly one cycle.
  - MEM_ADDR increments in the cycle after MEM_WE, so the write uses the pre-increment address.
  - Wrap at 2^ADDR_W−1 → 0 sets OVF. OVF stays set until the next accepted START.
- WR_STB rise in IDLE or ARM: no write.
- F5 fall outside RUN: not counted.
- Same-cycle F5 fall and WR_STB rise: both are handled independently in that cycle.
- FRAME_CNT never exceeds N_FRAMES; it holds its final value in IDLE.

Decomposition:
- Shared package acq_pkg holds:
  - state encoding: IDLE=0, ARM=1, TRIG=2, RUN=3, DRAIN=4 (3-bit);
  - default constants ADDR_W, FRAME_W, ARM_DLY, TRIG_LEN;
  - GEN_STEP=6, the FRC_IN cycles per generator step, used for the TRIG_LEN sanity check.
- One natural sub-module, edge_det: a 1-bit register that outputs rise/fall. Instantiate it three times (START, WR_STB, F5).
- Delay counters and the FSM stay in the top-level module.

Test Plan:
- Basic run (N_FRAMES=2):
  - START rise → BUSY and COUNTER_F_GO high 2 cycles later.
  - TRIG rises ARM_DLY=4 cycles after GO and stays high 8 cycles.
  - Two F5 falls → FRAME_CNT 1 then 2.
  - DONE pulses once after WR_STB is low.
- Write path: 5 WR_STB pulses (each ≥6 cycles high) in RUN → exactly 5 single-cycle MEM_WE, written at MEM_ADDR 0,1,2,3,4; final MEM_ADDR=5.
- Wrap (ADDR_W=3): 9 WR_STB pulses → addresses 0..7 then 0; OVF=1 after the 8th increment; the next START clears OVF.
- Abort: ABORT mid-RUN at FRAME_CNT=1 → next cycle BUSY=0, GO=0, TRIG=0, no DONE; FRAME_CNT stays 1.
- Edge cases:
  - N_FRAMES=0 START → DONE pulse, GO never rises.
  - START rise during RUN is ignored.
  - RES_HARD during TRIG → all outputs 0 on the next edge.
- Drain: last F5 fall while WR_STB=1 → GO stays high until WR_STB falls; the final MEM_WE precedes DONE.
